// File: rtl/simt_reconv_ctrl.sv
// simt_reconv_ctrl: warp PC / active-mask sequencer that splits divergent branches onto an
// external divergence stack and pops it back when the warp reaches its reconvergence PC.
module simt_reconv_ctrl #(
    parameter int LANES = 32,
    parameter int PC_WIDTH = 16,
    parameter int DEPTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [LANES-1:0]             act_mask,
    output logic                         pc_valid,
    input  logic                         adv,
    input  logic                         br_valid,
    output logic                         br_ready,
    input  logic [LANES-1:0]             br_taken,
    input  logic [PC_WIDTH-1:0]          br_target_pc,
    input  logic [PC_WIDTH-1:0]          br_fall_pc,
    input  logic [PC_WIDTH-1:0]          br_reconv_pc,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [LANES-1:0]             stk_push_mask,
    output logic [2*PC_WIDTH-1:0]        stk_push_data,
    input  logic [LANES-1:0]             stk_top_mask,
    input  logic [2*PC_WIDTH-1:0]        stk_top_data,
    input  logic                         stk_empty,
    input  logic [$clog2(DEPTH+1)-1:0]   stk_depth,
    output logic                         err_ovf,
    output logic [7:0]                   div_count
);
    localparam logic [1:0] RUN = 2'd0, PUSH_R = 2'd1, PUSH_E = 2'd2, ERR = 2'd3;
    logic [1:0] state;
    logic [PC_WIDTH-1:0] cur_reconv, tgt_pc, fall_pc, rcv_pc;
    logic [LANES-1:0] t_mask, n_mask, t, n;
    logic match, room;
    always_comb begin
        match = state == RUN && pc == cur_reconv && !stk_empty;
        pc_valid = state == RUN && !match;
        br_ready = pc_valid;
        stk_pop = !rst && match;
        stk_push = !rst && (state == PUSH_R || state == PUSH_E);
        stk_push_mask = state == PUSH_R ? act_mask : state == PUSH_E ? n_mask : '0;
        stk_push_data = state == PUSH_R ? {rcv_pc, cur_reconv} : state == PUSH_E ? {fall_pc, rcv_pc} : '0;
        t = act_mask & br_taken;
        n = act_mask & ~br_taken;
        room = int'(stk_depth) + 2 <= DEPTH;
    end
    // a divergent branch needs two free entries: reconvergence context plus the else path
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc <= RESET_PC;
            act_mask <= '1;
            cur_reconv <= '1;
            err_ovf <= 1'b0;
            div_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (match) begin
                        act_mask <= stk_top_mask;
                        pc <= stk_top_data[2*PC_WIDTH-1:PC_WIDTH];
                        cur_reconv <= stk_top_data[PC_WIDTH-1:0];
                    end else if (br_valid) begin
                        if (t == '0 || n == '0) begin
                            pc <= n == '0 ? br_target_pc : br_fall_pc;
                        end else if (room) begin
                            t_mask <= t;
                            n_mask <= n;
                            tgt_pc <= br_target_pc;
                            fall_pc <= br_fall_pc;
                            rcv_pc <= br_reconv_pc;
                            div_count <= div_count + {7'd0, div_count != 8'hff};
                            state <= PUSH_R;
                        end else begin
                            err_ovf <= 1'b1;
                            state <= ERR;
                        end
                    end else if (adv) begin
                        pc <= pc + 1'b1;
                    end
                end
                PUSH_R: state <= PUSH_E;
                PUSH_E: begin
                    act_mask <= t_mask;
                    pc <= tgt_pc;
                    cur_reconv <= rcv_pc;
                    state <= RUN;
                end
                default: state <= ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_simt_reconv_ctrl.sv
// tb_simt_reconv_ctrl: directed bench with a warp-level reference model, a bench-owned
// divergence stack and per-cycle output comparison.
module tb_simt_reconv_ctrl;
    logic clk, rst, adv, br_valid, br_ready, pc_valid, stk_push, stk_pop, stk_empty, err_ovf;
    logic [15:0] pc, br_target_pc, br_fall_pc, br_reconv_pc;
    logic [31:0] act_mask, br_taken, stk_push_mask, stk_push_data, stk_top_mask, stk_top_data;
    logic [3:0] stk_depth;
    logic [7:0] div_count;
    int n_chk = 0, n_fail = 0;

    typedef struct {logic [31:0] mask; logic [31:0] data;} ent_t;
    logic [31:0] sm [8];
    logic [31:0] sd [8];
    int sp = 0;
    int load_depth = -1;

    ent_t pend[$];
    logic [15:0] m_pc = 0, m_rcv = 16'hffff, d_pc = 0, d_rcv = 0;
    logic [31:0] m_mask = '1, d_mask = 0;
    logic [7:0] m_div = 0;
    bit m_halt = 0, m_ovf = 0;

    simt_reconv_ctrl dut (
        .clk(clk), .rst(rst), .pc(pc), .act_mask(act_mask), .pc_valid(pc_valid), .adv(adv),
        .br_valid(br_valid), .br_ready(br_ready), .br_taken(br_taken), .br_target_pc(br_target_pc),
        .br_fall_pc(br_fall_pc), .br_reconv_pc(br_reconv_pc), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_push_mask(stk_push_mask), .stk_push_data(stk_push_data), .stk_top_mask(stk_top_mask),
        .stk_top_data(stk_top_data), .stk_empty(stk_empty), .stk_depth(stk_depth),
        .err_ovf(err_ovf), .div_count(div_count)
    );

    assign stk_empty = sp == 0;
    assign stk_depth = 4'(sp);
    assign stk_top_mask = sp > 0 ? sm[sp-1] : '0;
    assign stk_top_data = sp > 0 ? sd[sp-1] : '0;

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic bit m_match();
        return pend.size() == 0 && !m_halt && m_pc == m_rcv && sp != 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: a divergent branch queues its two stack entries and defers the warp switch until both are out
    always @(posedge clk) begin
        bit do_push, do_pop;
        logic [31:0] pm, pd, t, n;
        do_push = !rst && pend.size() != 0;
        do_pop = !rst && m_match();
        pm = do_push ? pend[0].mask : '0;
        pd = do_push ? pend[0].data : '0;
        if (rst) begin
            m_pc = 0; m_mask = '1; m_rcv = 16'hffff; m_halt = 0; m_ovf = 0; m_div = 0;
            pend.delete();
        end else if (m_halt) begin
            m_halt = 1;
        end else if (pend.size() != 0) begin
            void'(pend.pop_front());
            if (pend.size() == 0) begin
                m_pc = d_pc; m_mask = d_mask; m_rcv = d_rcv;
            end
        end else if (do_pop) begin
            m_mask = sm[sp-1];
            m_pc = sd[sp-1][31:16];
            m_rcv = sd[sp-1][15:0];
        end else if (br_valid) begin
            t = m_mask & br_taken;
            n = m_mask & ~br_taken;
            if (t == 0 || n == 0) m_pc = n == 0 ? br_target_pc : br_fall_pc;
            else if (sp + 2 <= 8) begin
                pend.push_back('{mask: m_mask, data: {br_reconv_pc, m_rcv}});
                pend.push_back('{mask: n, data: {br_fall_pc, br_reconv_pc}});
                d_pc = br_target_pc; d_mask = t; d_rcv = br_reconv_pc;
                m_div = m_div + ((m_div != 8'hff) ? 8'd1 : 8'd0);
            end else begin
                m_halt = 1; m_ovf = 1;
            end
        end else if (adv) begin
            m_pc = m_pc + 16'd1;
        end
        if (load_depth >= 0) begin
            for (int i = 0; i < load_depth; i++) begin
                sm[i] <= 32'h0;
                sd[i] <= 32'h0;
            end
            sp <= load_depth;
        end else if (do_push) begin
            sm[sp] <= pm;
            sd[sp] <= pd;
            sp <= sp + 1;
        end else if (do_pop) begin
            sp <= sp - 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_push", stk_push, 0);
            chk("rst_pop", stk_pop, 0);
        end else begin
            chk("pc", pc, m_pc);
            chk("act_mask", act_mask, m_mask);
            chk("pc_valid", pc_valid, pend.size() == 0 && !m_halt && !m_match());
            chk("br_ready", br_ready, pend.size() == 0 && !m_halt && !m_match());
            chk("stk_push", stk_push, pend.size() != 0);
            chk("stk_pop", stk_pop, m_match());
            if (pend.size() != 0) begin
                chk("push_mask", stk_push_mask, pend[0].mask);
                chk("push_data", stk_push_data, pend[0].data);
            end
            chk("err_ovf", err_ovf, m_ovf);
            chk("div_count", div_count, m_div);
        end
    end

    task automatic apply(input bit a, input bit b, input logic [31:0] tk, input logic [15:0] tg, f, r);
        adv = a; br_valid = b; br_taken = tk; br_target_pc = tg; br_fall_pc = f; br_reconv_pc = r;
        @(posedge clk);
        #1;
        adv = 0; br_valid = 0;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic br(input logic [31:0] tk, input logic [15:0] tg, f, r);
        apply(0, 1, tk, tg, f, r);
    endtask

    initial begin
        rst = 1; adv = 0; br_valid = 0; br_taken = 0;
        br_target_pc = 0; br_fall_pc = 0; br_reconv_pc = 0; load_depth = 0;
        @(posedge clk); #1 load_depth = -1;
        @(posedge clk); #1 rst = 0;
        chk("lit_reset_pc", pc, 16'h0000);
        chk("lit_reset_mask", act_mask, 32'hffffffff);
        chk("lit_reset_valid", pc_valid, 1);
        chk("lit_reset_ready", br_ready, 1);
        chk("lit_reset_err", err_ovf, 0);
        chk("lit_reset_cmd", {stk_push, stk_pop}, 0);
        repeat (3) apply(1, 0, 0, 0, 0, 0);
        chk("lit_adv3", pc, 16'h0003);
        br('1, 16'h0040, 0, 0);
        chk("lit_uniform_pc", pc, 16'h0040);
        chk("lit_uniform_nopush", stk_push, 0);
        br('1, 16'h0010, 0, 0);
        br(32'h0000ffff, 16'h0020, 16'h0011, 16'h0030);
        chk("lit_push1", stk_push, 1);
        chk("lit_push1_mask", stk_push_mask, 32'hffffffff);
        chk("lit_push1_data", stk_push_data, 32'h0030ffff);
        chk("lit_push1_valid", pc_valid, 0);
        idle();
        chk("lit_push2_mask", stk_push_mask, 32'hffff0000);
        chk("lit_push2_data", stk_push_data, 32'h00110030);
        idle();
        chk("lit_taken_mask", act_mask, 32'h0000ffff);
        chk("lit_taken_pc", pc, 16'h0020);
        repeat (16) apply(1, 0, 0, 0, 0, 0);
        chk("lit_pop1", stk_pop, 1);
        idle();
        chk("lit_else_pc", pc, 16'h0011);
        chk("lit_else_mask", act_mask, 32'hffff0000);
        repeat (31) apply(1, 0, 0, 0, 0, 0);
        idle();
        chk("lit_reconv_pc", pc, 16'h0030);
        chk("lit_reconv_mask", act_mask, 32'hffffffff);
        chk("lit_reconv_div", div_count, 8'd1);
        chk("lit_reconv_valid", pc_valid, 1);
        apply(1, 1, '1, 16'h0100, 0, 0);
        chk("lit_br_over_adv", pc, 16'h0100);
        br(32'h0000ffff, 16'h0110, 16'h0101, 16'h0120);
        idle(); idle();
        br(32'h000000ff, 16'h0118, 16'h0111, 16'h0120);
        idle(); idle();
        chk("lit_nested_mask", act_mask, 32'h000000ff);
        br('1, 16'h0120, 0, 0);
        idle();
        chk("lit_nested_else", act_mask, 32'h0000ff00);
        br('1, 16'h0120, 0, 0);
        idle();
        chk("lit_consec_pop", stk_pop, 1);
        idle();
        chk("lit_consec_pc", pc, 16'h0101);
        br('1, 16'h0120, 0, 0);
        idle();
        chk("lit_nested_done", act_mask, 32'hffffffff);
        chk("lit_nested_div", div_count, 8'd3);
        br('1, 16'h0200, 0, 0);
        repeat (256) begin
            br(32'h0000ffff, 16'h0200, 16'h0201, 16'h0200);
            idle(); idle(); idle();
            br('1, 16'h0200, 0, 0);
            idle();
        end
        chk("lit_div_sat", div_count, 8'd255);
        chk("lit_sat_pc", pc, 16'h0200);
        br(32'h0000ffff, 16'h0300, 16'h0201, 16'h0400);
        idle();
        rst = 1; load_depth = 0;
        #1;
        chk("lit_rst_pushe_push", stk_push, 0);
        @(posedge clk); #1 rst = 0; load_depth = -1;
        chk("lit_after_rst_pc", pc, 16'h0000);
        chk("lit_after_rst_mask", act_mask, 32'hffffffff);
        chk("lit_after_rst_valid", pc_valid, 1);
        chk("lit_after_rst_div", div_count, 8'd0);
        rst = 1; load_depth = 7;
        @(posedge clk); #1 rst = 0; load_depth = -1;
        br(32'h0000ffff, 16'h0020, 16'h0001, 16'h0030);
        chk("lit_ovf_err", err_ovf, 1);
        chk("lit_ovf_valid", pc_valid, 0);
        chk("lit_ovf_ready", br_ready, 0);
        chk("lit_ovf_push", stk_push, 0);
        apply(1, 1, '1, 16'h0050, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        chk("lit_ovf_hold_err", err_ovf, 1);
        chk("lit_ovf_hold_pc", pc, 16'h0000);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("lit_ovf_clear", err_ovf, 0);
        chk("lit_ovf_clear_valid", pc_valid, 1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/simt_reconv_ctrl.md
SIMT_RECONV_CTRL -- requirements
Module: simt_reconv_ctrl

Interface
REQ-001 Parameters: LANES, default 32, lanes per warp. PC_WIDTH, default 16, PC bits. DEPTH, default 8, divergence-stack entries. RESET_PC, default 0, PC loaded at reset.
REQ-002 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 pc  out  PC_WIDTH  warp PC of the next instruction to issue.
REQ-005 act_mask  out  LANES  active lanes for pc.
REQ-006 pc_valid  out  1  pc/act_mask issuable this cycle.
REQ-007 adv  in  1  non-branch instruction at pc issued; sampled only when pc_valid=1.
REQ-008 br_valid / br_ready  in / out  1 / 1  branch-resolve handshake; transfer on br_valid&br_ready.
REQ-009 br_taken  in  LANES  per-lane taken predicate.
REQ-010 br_target_pc, br_fall_pc, br_reconv_pc  in  PC_WIDTH each  taken target, fall-through, post-dominator PC.
REQ-011 stk_push, stk_pop  out  1 each  divergence-stack commands, at most one asserted per cycle.
REQ-012 stk_push_mask  out  LANES; stk_push_data  out  2*PC_WIDTH  {resume_pc, reconv_pc}.
REQ-013 stk_top_mask  in  LANES; stk_top_data  in  2*PC_WIDTH; stk_empty  in  1; stk_depth  in  $clog2(DEPTH+1).
REQ-014 err_ovf  out  1  sticky stack-overflow error; div_count  out  8  saturating divergent-branch count.

Function
REQ-015 Internal registers: pc, act_mask, cur_reconv (PC_WIDTH; sentinel all-ones = none).
REQ-016 FSM states RUN, PUSH_R, PUSH_E, ERR.
REQ-017 RUN, reconv match (pc==cur_reconv and !stk_empty): pc_valid=0, br_ready=0, stk_pop=1; same edge load act_mask<=stk_top_mask, pc<=stk_top_data[hi], cur_reconv<=stk_top_data[lo].
REQ-018 Repeated matches after a pop pop again on consecutive cycles, one entry per cycle.
REQ-019 RUN, no match: pc_valid=1, br_ready=1.
REQ-020 br_valid has priority over adv; adv in the same cycle is ignored.
REQ-021 Accepted adv: pc<=pc+1, modulo 2^PC_WIDTH.
REQ-022 Accepted branch: T=act_mask&br_taken, N=act_mask&~br_taken.
REQ-023 Uniform branch (N==0 or T==0): pc<=br_target_pc if N==0, else br_fall_pc; act_mask unchanged; no stack command; stay RUN.
REQ-024 Divergent branch (T!=0 and N!=0) with stk_depth<=DEPTH-2: latch T, N, target, fall, reconv; div_count+1 saturating at 255; go PUSH_R.
REQ-025 PUSH_R: stk_push=1, mask=act_mask, data={br_reconv_pc, cur_reconv}; pc_valid=0, br_ready=0; go PUSH_E.
REQ-026 PUSH_E: stk_push=1, mask=N, data={br_fall_pc, br_reconv_pc}; pc_valid=0, br_ready=0.
REQ-027 PUSH_E same edge: act_mask<=T, pc<=br_target_pc, cur_reconv<=br_reconv_pc; go RUN.
REQ-028 Divergent branch with stk_depth>DEPTH-2: no push; err_ovf<=1; go ERR.
REQ-029 ERR: pc_valid=0, br_ready=0, no stack commands; held until rst.
REQ-030 stk_pop is never asserted while stk_empty=1.
REQ-031 stk_push is never asserted when fewer than 2 free entries existed at branch acceptance.
REQ-032 All outputs registered or decoded from state/registers only; no combinational path from br_valid or adv to stk_push or stk_pop.

Reset
REQ-033 rst wins over all activity, including mid-PUSH_R/PUSH_E.
REQ-034 Reset values: pc=RESET_PC, act_mask=all ones, cur_reconv=all ones, state RUN, err_ovf=0, div_count=0.
REQ-035 During the rst cycle: stk_push=0, stk_pop=0.
REQ-036 First cycle after reset: pc_valid=1 and br_ready=1 when stk_empty=1.

Verification (LANES=32, PC_WIDTH=16, DEPTH=8)
REQ-037 Reset, stk_empty=1 -> pc=0x0000, act_mask=FFFFFFFF, pc_valid=1, err_ovf=0, no stack commands.
REQ-038 Three adv pulses -> pc=0x0003; branch br_taken=FFFFFFFF, target 0x0040 -> next cycle pc=0x0040, no push.
REQ-039 Divergent case, setup: pc=0x0010; branch taken=0000FFFF, target 0x0020, fall 0x0011, reconv 0x0030.
REQ-040 Divergent case, pushes: cycle+1 push {FFFFFFFF, 0x0030, 0xFFFF}; cycle+2 push {FFFF0000, 0x0011, 0x0030}; cycle+3 act_mask=0000FFFF, pc=0x0020.
REQ-041 Divergent case, reconvergence: adv to pc=0x0030 -> pop, act_mask=FFFF0000, pc=0x0011; adv to pc=0x0030 -> pop, act_mask=FFFFFFFF, pc=0x0030, cur_reconv=FFFF, div_count=1.
REQ-042 stk_depth=7 plus divergent branch -> err_ovf=1, pc_valid=0, br_ready=0, no push; held until rst.
REQ-043 rst asserted while in PUSH_E -> no push that cycle; next cycle reset values per REQ-034.
REQ-044 br_valid and adv asserted together with a uniform branch to 0x0100 -> pc=0x0100, not pc+1.
